// File: rtl/matmul_seq10_if.sv
// Bundle of signals between the matmul sequencer and its operand/result RAMs and MAC.
// The master side is the sequencer. The slave side is the memory and MAC environment.
interface matmul_seq10_if #(
    parameter int N      = 10,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 7
);
    logic                       start;
    logic                       busy;
    logic                       done;
    logic                       a_rd_en;
    logic [ADDR_W-1:0]          a_addr;
    logic signed [DATA_W-1:0]   a_rd_data;
    logic                       b_rd_en;
    logic [ADDR_W-1:0]          b_addr;
    logic signed [DATA_W-1:0]   b_rd_data;
    logic [N*DATA_W-1:0]        a_vec;
    logic [N*DATA_W-1:0]        b_vec;
    logic                       mac_w_en;
    logic signed [ACC_W-1:0]    sop_in;
    logic                       c_wr_en;
    logic [ADDR_W-1:0]          c_addr;
    logic signed [ACC_W-1:0]    c_wr_data;

    modport master (
        input  start, a_rd_data, b_rd_data, sop_in,
        output busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               a_vec, b_vec, mac_w_en, c_wr_en, c_addr, c_wr_data
    );

    modport slave (
        output start, a_rd_data, b_rd_data, sop_in,
        input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr,
               a_vec, b_vec, mac_w_en, c_wr_en, c_addr, c_wr_data
    );
endinterface

// File: rtl/matmul_seq10.sv
// Sequencer that computes C = A x B for NxN signed matrices by feeding row/column
// vectors to an N-wide dot-product MAC and writing each SOP to the C RAM.
module matmul_seq10 #(
    parameter int N       = 10,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 16,
    parameter int ADDR_W  = 7,
    parameter int MAC_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    matmul_seq10_if.master bus
);
    localparam int IDX_W  = $clog2(N);
    localparam int WAIT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_CAPT, S_MAC, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic [N*DATA_W-1:0]      a_vec_q, a_vec_d, b_vec_q, b_vec_d;
    logic [ADDR_W-1:0]        a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d;
    logic signed [ACC_W-1:0]  c_wr_data_q, c_wr_data_d;
    logic [IDX_W-1:0]         lane;
    logic                     a_rd_en, b_rd_en, mac_w_en, c_wr_en, busy, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            wait_q      <= '0;
            a_vec_q     <= '0;
            b_vec_q     <= '0;
            a_addr_q    <= '0;
            b_addr_q    <= '0;
            c_addr_q    <= '0;
            c_wr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            a_vec_q     <= a_vec_d;
            b_vec_q     <= b_vec_d;
            a_addr_q    <= a_addr_d;
            b_addr_q    <= b_addr_d;
            c_addr_q    <= c_addr_d;
            c_wr_data_q <= c_wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                if (k_q == IDX_W'(N - 1)) begin
                    state_d = S_CAPT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_CAPT: state_d = S_MAC;
            S_MAC: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(MAC_LAT - 1)) begin
                    state_d = S_WRITE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (j_q != IDX_W'(N - 1)) begin
                    j_d     = j_q + 1'b1;
                    state_d = S_FETCH;
                end else if (i_q != IDX_W'(N - 1)) begin
                    j_d     = '0;
                    i_d     = i_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data lags its request by one cycle, so FETCH k loads lane k-1 and CAPT loads the last lane.
    always_comb begin
        a_rd_en     = 1'b0;
        b_rd_en     = 1'b0;
        mac_w_en    = 1'b0;
        c_wr_en     = 1'b0;
        a_addr_d    = a_addr_q;
        b_addr_d    = b_addr_q;
        c_addr_d    = c_addr_q;
        c_wr_data_d = c_wr_data_q;
        a_vec_d     = a_vec_q;
        b_vec_d     = b_vec_q;
        lane        = (state_q == S_CAPT) ? IDX_W'(N - 1) : (k_q - 1'b1);
        case (state_q)
            S_FETCH: begin
                b_rd_en  = 1'b1;
                b_addr_d = ADDR_W'(k_q) * ADDR_W'(N) + ADDR_W'(j_q);
                if (j_q == '0) begin
                    a_rd_en  = 1'b1;
                    a_addr_d = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(k_q);
                end
                if (k_q != '0) begin
                    b_vec_d[DATA_W*lane +: DATA_W] = bus.b_rd_data;
                    if (j_q == '0) begin
                        a_vec_d[DATA_W*lane +: DATA_W] = bus.a_rd_data;
                    end
                end
            end
            S_CAPT: begin
                b_vec_d[DATA_W*lane +: DATA_W] = bus.b_rd_data;
                if (j_q == '0) begin
                    a_vec_d[DATA_W*lane +: DATA_W] = bus.a_rd_data;
                end
            end
            S_MAC: mac_w_en = 1'b1;
            S_WRITE: begin
                c_wr_en     = 1'b1;
                c_addr_d    = ADDR_W'(i_q) * ADDR_W'(N) + ADDR_W'(j_q);
                c_wr_data_d = bus.sop_in;
            end
            default: ;
        endcase
        busy = (state_q != S_IDLE) && (state_q != S_DONE);
        done = (state_q == S_DONE);
        // A reset arriving mid-operation must not let the in-flight write or done escape.
        if (rst) begin
            a_rd_en  = 1'b0;
            b_rd_en  = 1'b0;
            mac_w_en = 1'b0;
            c_wr_en  = 1'b0;
            busy     = 1'b0;
            done     = 1'b0;
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.a_rd_en   = a_rd_en;
    assign bus.b_rd_en   = b_rd_en;
    assign bus.mac_w_en  = mac_w_en;
    assign bus.c_wr_en   = c_wr_en;
    assign bus.a_addr    = a_addr_d;
    assign bus.b_addr    = b_addr_d;
    assign bus.c_addr    = c_addr_d;
    assign bus.c_wr_data = c_wr_data_d;
    assign bus.a_vec     = a_vec_q;
    assign bus.b_vec     = b_vec_q;
endmodule

// File: tb/tb_matmul_seq10.sv
// Self-checking bench for matmul_seq10: RAM and MAC models around the sequencer,
// with every C entry compared against a plain matrix-product reference.
module tb_matmul_seq10;
    localparam int N       = 10;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 16;
    localparam int ADDR_W  = 7;
    localparam int MAC_LAT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_seq10_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    matmul_seq10 #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    logic signed [DATA_W-1:0] mem_a [N*N];
    logic signed [DATA_W-1:0] mem_b [N*N];
    logic [ACC_W-1:0]         mem_c [N*N];
    int c_addr_log[$];
    int b_addr_log[$];
    int cyc = 0;
    int busy_count = 0;
    int done_count = 0;
    int done_cyc = 0;
    int a_rd_count = 0;
    int err_count = 0;
    int check_count = 0;

    function automatic logic [ACC_W-1:0] dotProduct(input logic [N*DATA_W-1:0] av, input logic [N*DATA_W-1:0] bv);
        int s = 0;
        logic signed [DATA_W-1:0] ea, eb;
        for (int k = 0; k < N; k++) begin
            ea = av[DATA_W*k +: DATA_W];
            eb = bv[DATA_W*k +: DATA_W];
            s += int'(ea) * int'(eb);
        end
        return s[ACC_W-1:0];
    endfunction

    function automatic int refC(input int r, input int c);
        int s = 0;
        for (int k = 0; k < N; k++) s += int'(mem_a[r*N+k]) * int'(mem_b[k*N+c]);
        return s & 32'h0000_FFFF;
    endfunction

    // Synchronous-read operand RAMs, a MAC with one cycle of latency and the C RAM.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.a_rd_en) bus.a_rd_data <= mem_a[bus.a_addr];
        if (bus.b_rd_en) bus.b_rd_data <= mem_b[bus.b_addr];
        if (bus.mac_w_en) bus.sop_in <= dotProduct(bus.a_vec, bus.b_vec);
        if (bus.c_wr_en) begin
            mem_c[bus.c_addr] <= bus.c_wr_data;
            c_addr_log.push_back(int'(bus.c_addr));
        end
    end

    always @(negedge clk) begin
        if (bus.busy) busy_count <= busy_count + 1;
        if (bus.a_rd_en) a_rd_count <= a_rd_count + 1;
        if (bus.b_rd_en) b_addr_log.push_back(int'(bus.b_addr));
        if (bus.done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(output int c0);
        @(negedge clk);
        bus.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic checkMatrix(input string tag);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                checkOutput($sformatf("%s C[%0d][%0d]", tag, r, c), int'(mem_c[r*N+c]), refC(r, c));
    endtask

    // Full run with optional start pulse while busy, then timing, count and result checks.
    task automatic runMatmul(input string tag, input int poke_at);
        int c0;
        int done_base  = done_count;
        int busy_base  = busy_count;
        int a_base     = a_rd_count;
        int c_base     = c_addr_log.size();
        int b_base     = b_addr_log.size();
        int order_ok   = 1;
        applyStimulus(c0);
        for (int t = 0; t < 2000 && done_count == done_base; t++) begin
            @(negedge clk);
            bus.start = (t == poke_at) ? 1'b1 : 1'b0;
        end
        bus.start = 1'b0;
        @(negedge clk);
        checkOutput({tag, " done_pulses"}, done_count - done_base, 1);
        checkOutput({tag, " done_latency"}, done_cyc - c0, 1401);
        checkOutput({tag, " busy_cycles"}, busy_count - busy_base, 1400);
        checkOutput({tag, " a_reads"}, a_rd_count - a_base, 100);
        checkOutput({tag, " b_reads"}, b_addr_log.size() - b_base, 1000);
        checkOutput({tag, " writes"}, c_addr_log.size() - c_base, 100);
        for (int n = 0; n < 100 && c_base + n < c_addr_log.size(); n++)
            if (c_addr_log[c_base+n] != n) order_ok = 0;
        checkOutput({tag, " write_order"}, order_ok, 1);
        if (b_addr_log.size() >= b_base + 380)
            for (int k = 0; k < N; k++)
                checkOutput($sformatf("%s b_addr(3,7,k=%0d)", tag, k), b_addr_log[b_base + 370 + k], k*N + 7);
        checkMatrix(tag);
    endtask

    task automatic fillRandom();
        for (int n = 0; n < N*N; n++) begin
            mem_a[n] = DATA_W'($urandom);
            mem_b[n] = DATA_W'($urandom);
        end
    endtask

    initial begin
        int found;
        int c0;
        int done_base;
        int c_base;
        bus.start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", int'(bus.busy), 0);
        checkOutput("reset done", int'(bus.done), 0);
        checkOutput("reset a_rd_en", int'(bus.a_rd_en), 0);
        checkOutput("reset b_rd_en", int'(bus.b_rd_en), 0);
        checkOutput("reset mac_w_en", int'(bus.mac_w_en), 0);
        checkOutput("reset c_wr_en", int'(bus.c_wr_en), 0);
        checkOutput("reset a_addr", int'(bus.a_addr), 0);
        checkOutput("reset b_addr", int'(bus.b_addr), 0);
        checkOutput("reset c_addr", int'(bus.c_addr), 0);
        checkOutput("reset c_wr_data", int'(bus.c_wr_data), 0);
        checkOutput("reset a_vec", int'(|bus.a_vec), 0);
        checkOutput("reset b_vec", int'(|bus.b_vec), 0);

        $display("[TB] identity run");
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mem_a[r*N+c] = (r == c) ? 8'sd1 : 8'sd0;
                mem_b[r*N+c] = DATA_W'(r*10 + c - 50);
            end
        runMatmul("identity", -1);

        $display("[TB] overflow run");
        for (int n = 0; n < N*N; n++) begin
            mem_a[n] = -8'sd128;
            mem_b[n] = -8'sd128;
        end
        runMatmul("overflow", -1);
        checkOutput("overflow C[9][9] literal", int'(mem_c[99]), 32'h8000);

        $display("[TB] random run with start while busy");
        fillRandom();
        runMatmul("random_busy_start", 48);

        $display("[TB] reset during write of C[2][5]");
        fillRandom();
        done_base = done_count;
        c_base = c_addr_log.size();
        found = 0;
        applyStimulus(c0);
        for (int t = 0; t < 2000 && found == 0; t++) begin
            @(negedge clk);
            if (bus.c_wr_en && bus.c_addr == ADDR_W'(25)) found = 1;
        end
        checkOutput("mid_reset reached C25", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_reset busy", int'(bus.busy), 0);
        checkOutput("mid_reset c_wr_en", int'(bus.c_wr_en), 0);
        checkOutput("mid_reset c_addr", int'(bus.c_addr), 0);
        checkOutput("mid_reset b_addr", int'(bus.b_addr), 0);
        checkOutput("mid_reset a_vec", int'(|bus.a_vec), 0);
        checkOutput("mid_reset writes", c_addr_log.size() - c_base, 25);
        repeat (100) @(negedge clk);
        checkOutput("mid_reset no_done", done_count - done_base, 0);
        checkOutput("mid_reset still_idle", int'(bus.busy), 0);

        $display("[TB] fresh run after reset");
        fillRandom();
        runMatmul("after_reset", -1);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end
endmodule
